// File: rtl/mips_16_debug_ctrl.sv
// Host sequencer for mips_16: imem load, budget/breakpoint runs, register readback. LOAD/READREG respond 2 cycles after accept.
// RUN responds after N or fewer core cycles. Backpressure: cmd_ready is only high in HALT; a held command waits there.
module mips_16_debug_ctrl #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [PC_WIDTH-1:0]    cmd_addr,
    input  logic [CNT_WIDTH-1:0]   cmd_data,
    input  logic                   halt_req,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic [1:0]             rsp_status,
    output logic                   core_rst,
    output logic                   core_stall,
    input  logic [PC_WIDTH-1:0]    core_pc,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_waddr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic [2:0]             rf_raddr,
    input  logic [DATA_WIDTH-1:0]  rf_rdata
);

    localparam logic [2:0] ST_HALT = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_RUN     = 2'd1;
    localparam logic [1:0] OP_RUN_BP  = 2'd2;
    localparam logic [1:0] OP_READREG = 2'd3;

    localparam logic [1:0] STS_OK     = 2'b00;
    localparam logic [1:0] STS_BUDGET = 2'b01;
    localparam logic [1:0] STS_BP     = 2'b10;
    localparam logic [1:0] STS_HALTED = 2'b11;

    logic [2:0]            state;
    logic [CNT_WIDTH-1:0]  counter;
    logic [PC_WIDTH-1:0]   bp_pc;
    logic                  bp_en;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  resp_pc;
    logic                  cmd_fire;
    logic                  bp_hit;

    assign cmd_ready  = (state == ST_HALT);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign bp_hit     = (state == ST_RUN) && bp_en && (core_pc == bp_pc);
    // Breakpoint and abort must freeze the core in the very cycle they are seen.
    assign core_stall = (state != ST_RUN) || bp_hit || halt_req;
    assign rsp_valid  = (state == ST_RESP);
    // Run responses report the live PC while the core is frozen in RESP; it is latched on the way out.
    assign rsp_data   = (rsp_valid && resp_pc) ? DATA_WIDTH'(core_pc) : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HALT;
            core_rst   <= 1'b1;
            counter    <= '0;
            bp_pc      <= '0;
            bp_en      <= 1'b0;
            data_q     <= '0;
            resp_pc    <= 1'b0;
            rsp_status <= STS_OK;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            rf_raddr   <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_HALT: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                core_rst   <= 1'b1;
                                imem_we    <= 1'b1;
                                imem_waddr <= cmd_addr;
                                imem_wdata <= cmd_data[INSTR_WIDTH-1:0];
                                state      <= ST_LOAD;
                            end
                            OP_RUN, OP_RUN_BP: begin
                                core_rst <= 1'b0;
                                counter  <= cmd_data;
                                bp_pc    <= cmd_addr;
                                bp_en    <= (cmd_op == OP_RUN_BP);
                                if (cmd_data == '0) begin
                                    rsp_status <= STS_BUDGET;
                                    resp_pc    <= 1'b1;
                                    state      <= ST_RESP;
                                end else begin
                                    state <= ST_RUN;
                                end
                            end
                            default: begin
                                rf_raddr <= cmd_addr[2:0];
                                state    <= ST_READ;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    data_q     <= DATA_WIDTH'(imem_wdata);
                    rsp_status <= STS_OK;
                    resp_pc    <= 1'b0;
                    state      <= ST_RESP;
                end
                ST_RUN: begin
                    if (bp_hit) begin
                        rsp_status <= STS_BP;
                        resp_pc    <= 1'b1;
                        state      <= ST_RESP;
                    end else if (halt_req) begin
                        rsp_status <= STS_HALTED;
                        resp_pc    <= 1'b1;
                        state      <= ST_RESP;
                    end else if (counter == CNT_WIDTH'(1)) begin
                        rsp_status <= STS_BUDGET;
                        resp_pc    <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        counter <= counter - CNT_WIDTH'(1);
                    end
                end
                ST_READ: begin
                    data_q     <= rf_rdata;
                    rsp_status <= STS_OK;
                    resp_pc    <= 1'b0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_pc) begin
                        data_q <= DATA_WIDTH'(core_pc);
                    end
                    state <= ST_HALT;
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_16_debug_ctrl.sv
// Bench for mips_16_debug_ctrl with a counting-PC core stand-in and a behavioural register file.
module tb_mips_16_debug_ctrl;
    localparam int PW = 8;
    localparam int IW = 16;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_BP   = 2'd2;
    localparam logic [1:0] OP_RD   = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [PW-1:0] cmd_addr = '0;
    logic [CW-1:0] cmd_data = '0;
    logic          halt_req = 1'b0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic          core_rst;
    logic          core_stall;
    logic [PW-1:0] core_pc;
    logic          imem_we;
    logic [PW-1:0] imem_waddr;
    logic [IW-1:0] imem_wdata;
    logic [2:0]    rf_raddr;
    logic [DW-1:0] rf_rdata;

    logic [DW-1:0] rf_model [0:7];
    logic [PW-1:0] pc_q = '0;

    int checks = 0;
    int failures = 0;
    int model_pc = 0;

    always #5 clk = ~clk;

    // Core stand-in: PC counts up whenever it is neither reset nor stalled.
    always @(posedge clk) begin
        if (core_rst) pc_q <= '0;
        else if (!core_stall) pc_q <= pc_q + 1'b1;
    end
    assign core_pc  = pc_q;
    assign rf_rdata = rf_model[rf_raddr];

    mips_16_debug_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .halt_req(halt_req),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .core_rst(core_rst), .core_stall(core_stall), .core_pc(core_pc),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    // Issues one command and observes everything up to its response; lat counts cycles after accept.
    task automatic do_cmd(input logic [1:0] op, input logic [PW-1:0] addr, input logic [CW-1:0] data,
                          input int halt_at, output logic [1:0] st, output logic [DW-1:0] dat,
                          output int lat, output int unst, output int we_cnt,
                          output logic [PW-1:0] we_addr, output logic [IW-1:0] we_data,
                          output logic rst_c1);
        bit got;
        got = 0; lat = -1; unst = 0; we_cnt = 0; we_addr = '0; we_data = '0;
        st = '0; dat = '0; rst_c1 = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 3000 && !got; c++) begin
            halt_req = (c - 1 == halt_at);
            @(negedge clk);
            if (c == 1) rst_c1 = core_rst;
            if (!core_stall) unst++;
            if (imem_we) begin
                we_cnt++; we_addr = imem_waddr; we_data = imem_wdata;
            end
            if (rsp_valid) begin
                got = 1; lat = c; st = rsp_status; dat = rsp_data;
            end
            @(posedge clk); #1;
        end
        halt_req = 1'b0;
    endtask

    // Expected outcome is derived from the rule set: stop index is the earliest of breakpoint distance,
    // abort cycle and last budget cycle, with breakpoint > abort > budget on ties.
    task automatic run_and_check(input string name, input logic [1:0] op, input int n, input int bp,
                                 input int halt_at);
        int p, s, ex, exp_lat, d, exp_pc;
        logic [1:0] exp_st;
        logic [1:0] st; logic [DW-1:0] dat; int lat, unst, wc;
        logic [PW-1:0] wa; logic [IW-1:0] wd; logic r1;
        p = model_pc;
        if (n == 0) begin
            exp_st = 2'b01; ex = 0; exp_lat = 1;
        end else begin
            s = n - 1; exp_st = 2'b01; ex = n;
            if (halt_at >= 0 && halt_at <= s) begin
                s = halt_at; exp_st = 2'b11; ex = halt_at;
            end
            d = (bp - p) & 255;
            if (op == OP_BP && d <= s) begin
                s = d; exp_st = 2'b10; ex = d;
            end
            exp_lat = s + 2;
        end
        exp_pc = (p + ex) & 255;
        do_cmd(op, PW'(bp), CW'(n), halt_at, st, dat, lat, unst, wc, wa, wd, r1);
        checks++;
        if (st !== exp_st) begin
            failures++; $display("FAIL %s status got=%0d exp=%0d", name, st, exp_st);
        end
        checks++;
        if (dat !== DW'(exp_pc)) begin
            failures++; $display("FAIL %s stop_pc got=%0d exp=%0d", name, dat, exp_pc);
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++; $display("FAIL %s rsp_latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        checks++;
        if (unst !== ex) begin
            failures++; $display("FAIL %s unstalled_cycles got=%0d exp=%0d", name, unst, ex);
        end
        checks++;
        if (r1 !== 1'b0) begin
            failures++; $display("FAIL %s core_rst_after_accept got=%0b exp=0", name, r1);
        end
        model_pc = exp_pc;
    endtask

    task automatic load_and_check(input string name, input logic [PW-1:0] addr, input logic [IW-1:0] word,
                                  input int halt_at);
        logic [1:0] st; logic [DW-1:0] dat; int lat, unst, wc;
        logic [PW-1:0] wa; logic [IW-1:0] wd; logic r1;
        do_cmd(OP_LOAD, addr, CW'(word), halt_at, st, dat, lat, unst, wc, wa, wd, r1);
        checks++;
        if (wc !== 1 || wa !== addr || wd !== word) begin
            failures++;
            $display("FAIL %s imem_write got cnt=%0d addr=%0d data=%h exp cnt=1 addr=%0d data=%h",
                     name, wc, wa, wd, addr, word);
        end
        checks++;
        if (st !== 2'b00 || dat !== DW'(word) || lat !== 2) begin
            failures++;
            $display("FAIL %s echo got st=%0d data=%h lat=%0d exp st=0 data=%h lat=2",
                     name, st, dat, lat, word);
        end
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== DW'(word)) begin
            failures++;
            $display("FAIL %s after_rsp got core_rst=%0b rsp_valid=%0b rsp_data=%h exp 1 0 %h",
                     name, core_rst, rsp_valid, rsp_data, word);
        end
        model_pc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b1 || core_stall !== 1'b1 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rst=%0b stall=%0b ready=%0b vld=%0b exp 1 1 1 0",
                     core_rst, core_stall, cmd_ready, rsp_valid);
        end
        checks++;
        if (rsp_data !== '0 || rsp_status !== 2'b00 || imem_we !== 1'b0 || rf_raddr !== 3'd0) begin
            failures++;
            $display("FAIL reset_data got data=%h st=%0d we=%0b raddr=%0d exp 0 0 0 0",
                     rsp_data, rsp_status, imem_we, rf_raddr);
        end
        rst = 1'b0;
        model_pc = 0;
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++)
            load_and_check("load", PW'(i), IW'($urandom), (i % 2 == 1) ? 0 : -1);
    endtask

    task automatic test_run();
        run_and_check("run_n20", OP_RUN, 20, 0, -1);
        for (int i = 0; i < 4; i++)
            run_and_check("run_rand", OP_RUN, $urandom_range(1, 60), $urandom_range(0, 255), -1);
    endtask

    task automatic test_breakpoint();
        load_and_check("load_prog", PW'(4), IW'($urandom), -1);
        run_and_check("bp6", OP_BP, 400, 6, -1);
        run_and_check("bp_first_cycle", OP_BP, 50, model_pc, -1);
        for (int i = 0; i < 5; i++)
            run_and_check("bp_rand", OP_BP, $urandom_range(0, 60), (model_pc + $urandom_range(0, 40)) & 255,
                          ($urandom_range(0, 2) == 0) ? $urandom_range(0, 50) : -1);
    endtask

    task automatic test_readreg();
        logic [1:0] st; logic [DW-1:0] dat; int lat, unst, wc;
        logic [PW-1:0] wa; logic [IW-1:0] wd; logic r1;
        logic [PW-1:0] a;
        for (int r = 0; r < 8; r++) rf_model[r] = DW'($urandom);
        rf_model[1] = DW'($urandom_range(1, 255));
        rf_model[2] = DW'($urandom_range(1, 255));
        rf_model[3] = DW'(rf_model[1] * rf_model[2]);
        for (int k = 0; k < 8; k++) begin
            a = PW'($urandom);
            a[2:0] = (k == 0) ? 3'd3 : 3'(k);
            do_cmd(OP_RD, a, CW'($urandom), -1, st, dat, lat, unst, wc, wa, wd, r1);
            checks++;
            if (st !== 2'b00 || dat !== rf_model[a[2:0]] || lat !== 2) begin
                failures++;
                $display("FAIL readreg r%0d got st=%0d data=%h lat=%0d exp st=0 data=%h lat=2",
                         a[2:0], st, dat, lat, rf_model[a[2:0]]);
            end
        end
    endtask

    task automatic test_halt();
        run_and_check("halt_and_bp", OP_BP, 100, (model_pc + 5) & 255, 5);
        run_and_check("halt_mid_run", OP_RUN, 100, 0, 7);
        run_and_check("halt_last_cycle", OP_RUN, 10, 0, 9);
        run_and_check("halt_first_cycle", OP_RUN, 10, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] w1, w2;
        int we_cyc[$]; int rsp_cyc[$];
        logic [PW-1:0] last_wa; logic [DW-1:0] last_rsp; bit ready_early;
        w1 = IW'($urandom); w2 = IW'($urandom); ready_early = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_addr = PW'(10); cmd_data = CW'(w1);
        @(posedge clk); #1;
        cmd_addr = PW'(11); cmd_data = CW'(w2);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (imem_we) begin we_cyc.push_back(c); last_wa = imem_waddr; end
            if (rsp_valid) begin rsp_cyc.push_back(c); last_rsp = rsp_data; end
            if (c < 3 && cmd_ready) ready_early = 1;
            @(posedge clk); #1;
            if (c == 3) cmd_valid = 1'b0;
        end
        checks++;
        if (ready_early) begin
            failures++; $display("FAIL b2b_ready got ready while busy exp low");
        end
        checks++;
        if (we_cyc.size() !== 2 || we_cyc[0] !== 1 || we_cyc[1] !== 4 || last_wa !== PW'(11)) begin
            failures++;
            $display("FAIL b2b_writes got count=%0d last_addr=%0d exp count=2 at cycles 1,4 last_addr=11",
                     we_cyc.size(), last_wa);
        end
        checks++;
        if (rsp_cyc.size() !== 2 || rsp_cyc[1] !== 5 || last_rsp !== DW'(w2)) begin
            failures++;
            $display("FAIL b2b_rsp got count=%0d last_data=%h exp count=2 second at cycle 5 data=%h",
                     rsp_cyc.size(), last_rsp, w2);
        end
        model_pc = 0;
    endtask

    task automatic test_reset_mid_run();
        int stray;
        stray = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_addr = '0; cmd_data = CW'(200);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b1 || core_stall !== 1'b1 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_run got rst=%0b stall=%0b ready=%0b vld=%0b exp 1 1 1 0",
                     core_rst, core_stall, cmd_ready, rsp_valid);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++; $display("FAIL rst_mid_run_rsp got %0d responses exp 0", stray);
        end
        model_pc = 0;
        run_and_check("run_n0", OP_RUN, 0, 0, -1);
        run_and_check("run_bp_n0", OP_BP, 0, model_pc, -1);
    endtask

    initial begin
        for (int r = 0; r < 8; r++) rf_model[r] = '0;
        test_reset();
        test_load();
        test_run();
        test_breakpoint();
        test_readreg();
        test_halt();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
